// File: rtl/random_pkg.sv
// rtl/random_pkg.sv - shared state encoding and LFSR tap table for random_roller
package random_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROLL  = 2'd1,
        ST_PAUSE = 2'd2
    } roll_state_t;

    localparam int MAX_W = 16;

    // Tap masks for a right-shifting Fibonacci LFSR: bit 0 plus the lower
    // terms of a primitive polynomial x^W + ... + 1.
    function automatic logic [MAX_W-1:0] lfsr_taps(input int w);
        case (w)
            4:       lfsr_taps = 16'h0009;
            5:       lfsr_taps = 16'h0009;
            6:       lfsr_taps = 16'h0021;
            7:       lfsr_taps = 16'h0041;
            8:       lfsr_taps = 16'h0071;
            9:       lfsr_taps = 16'h0021;
            10:      lfsr_taps = 16'h0081;
            11:      lfsr_taps = 16'h0201;
            12:      lfsr_taps = 16'h0C11;
            13:      lfsr_taps = 16'h1901;
            14:      lfsr_taps = 16'h3005;
            15:      lfsr_taps = 16'h4001;
            16:      lfsr_taps = 16'hA011;
            default: lfsr_taps = 16'h0009;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - maximal-length Fibonacci LFSR with seed load and step enable
module lfsr_core
    import random_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_step,
    input  logic         i_load,
    input  logic [W-1:0] i_seed,
    output logic [W-1:0] o_value,
    output logic [W-1:0] o_next
);

    localparam logic [MAX_W-1:0] TAPS_FULL = lfsr_taps(W);
    localparam logic [W-1:0]     TAPS      = TAPS_FULL[W-1:0];

    logic [W-1:0] r;

    assign o_next  = {^(r & TAPS), r[W-1:1]};
    assign o_value = r;

    // The all-zero state is a lock-up state, so a zero seed becomes 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r <= W'(1);
        end else if (i_load) begin
            r <= (i_seed == '0) ? W'(1) : i_seed;
        end else if (i_step) begin
            r <= o_next;
        end
    end

endmodule

// File: rtl/random_roller.sv
// rtl/random_roller.sv - slowing dice roller with pause and finished-roll history
module random_roller
    import random_pkg::*;
#(
    parameter int W            = 4,
    parameter int NPHASE       = 5,
    parameter int PHASE_CYCLES = 100_000_000,
    parameter int BASE_DIV     = 3_125_000,
    parameter int HIST_DEPTH   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_prev,
    input  logic                        i_seed_load,
    input  logic [W-1:0]                i_seed,
    output logic [W-1:0]                o_random_out,
    output logic                        o_busy,
    output logic [$clog2(HIST_DEPTH):0] o_hist_idx
);

    localparam int     IW      = $clog2(HIST_DEPTH) + 1;
    localparam longint DIV_MAX = longint'(BASE_DIV) << (NPHASE - 1);
    localparam int     DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int     PW      = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int     PHW     = (NPHASE > 1) ? $clog2(NPHASE) : 1;

    roll_state_t    state, state_n;
    logic [DW-1:0]  divcnt, div_limit;
    logic [PW-1:0]  phcnt;
    logic [PHW-1:0] phase;
    logic [IW-1:0]  hist_idx, hist_valid;
    logic [W-1:0]   hist [HIST_DEPTH];
    logic [W-1:0]   hist_sel, lfsr_q, lfsr_next;
    logic           div_term, ph_term, last_phase;
    logic           go, count_en, lfsr_step, lfsr_load, push, idx_inc;

    lfsr_core #(.W(W)) u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (lfsr_step),
        .i_load  (lfsr_load),
        .i_seed  (i_seed),
        .o_value (lfsr_q),
        .o_next  (lfsr_next)
    );

    assign div_limit  = DW'((longint'(BASE_DIV) << phase) - 1);
    assign div_term   = (divcnt == div_limit);
    assign ph_term    = (phcnt == PW'(PHASE_CYCLES - 1));
    assign last_phase = (phase == PHW'(NPHASE - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        go        = 1'b0;
        count_en  = 1'b0;
        lfsr_step = 1'b0;
        lfsr_load = 1'b0;
        push      = 1'b0;
        idx_inc   = 1'b0;
        if (i_start) begin
            state_n = ST_ROLL;
            go      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_prev) begin
                        idx_inc = (hist_idx + IW'(1) < hist_valid);
                    end else if (i_seed_load) begin
                        lfsr_load = 1'b1;
                    end
                end
                ST_ROLL: begin
                    if (i_prev) begin
                        state_n = ST_PAUSE;
                    end else begin
                        count_en  = 1'b1;
                        lfsr_step = div_term;
                        if (ph_term && last_phase) begin
                            state_n = ST_IDLE;
                            push    = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_prev) begin
                        state_n = ST_ROLL;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Counters, history shift register and browse index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            divcnt     <= '0;
            phcnt      <= '0;
            phase      <= '0;
            hist_idx   <= '0;
            hist_valid <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else begin
            if (go) begin
                divcnt   <= '0;
                phcnt    <= '0;
                phase    <= '0;
                hist_idx <= '0;
            end else if (count_en) begin
                if (ph_term) begin
                    divcnt <= '0;
                    phcnt  <= '0;
                    phase  <= last_phase ? '0 : phase + PHW'(1);
                end else begin
                    phcnt  <= phcnt + PW'(1);
                    divcnt <= div_term ? '0 : divcnt + DW'(1);
                end
            end
            if (idx_inc) begin
                hist_idx <= hist_idx + IW'(1);
            end
            if (push) begin
                hist[0] <= lfsr_step ? lfsr_next : lfsr_q;
                for (int k = 1; k < HIST_DEPTH; k++) begin
                    hist[k] <= hist[k-1];
                end
                if (hist_valid != IW'(HIST_DEPTH)) begin
                    hist_valid <= hist_valid + IW'(1);
                end
            end
        end
    end

    always_comb begin
        hist_sel = '0;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            if (IW'(k) == hist_idx) begin
                hist_sel = hist[k];
            end
        end
    end

    // Unwritten history entries are held at zero, so an empty history reads 0.
    always_comb begin
        case (state)
            ST_ROLL:  o_random_out = lfsr_q;
            ST_PAUSE: o_random_out = hist[0];
            default:  o_random_out = hist_sel;
        endcase
    end

    assign o_busy     = (state != ST_IDLE);
    assign o_hist_idx = hist_idx;

endmodule

// File: tb/tb_random_roller.sv
// tb/tb_random_roller.sv - randomized and directed checks of random_roller against a reference model
module tb_random_roller;

    localparam int W            = 4;
    localparam int NPHASE       = 3;
    localparam int BASE_DIV     = 2;
    localparam int PHASE_CYCLES = 16;
    localparam int HIST_DEPTH   = 2;
    localparam int IW           = $clog2(HIST_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, start, prev, seed_load;
    logic [W-1:0]  seed;
    logic [W-1:0]  out;
    logic          busy;
    logic [IW-1:0] idx;

    always #5 clk = ~clk;

    random_roller #(
        .W(W), .NPHASE(NPHASE), .PHASE_CYCLES(PHASE_CYCLES),
        .BASE_DIV(BASE_DIV), .HIST_DEPTH(HIST_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_prev       (prev),
        .i_seed_load  (seed_load),
        .i_seed       (seed),
        .o_random_out (out),
        .o_busy       (busy),
        .o_hist_idx   (idx)
    );

    int checks = 0;
    int errors = 0;

    int m_lfsr = 1;
    int m_t    = 0;
    int m_idx  = 0;
    bit m_roll = 0;
    bit m_pause = 0;
    int m_hist[$];

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lfsr_step(input int r);
        return (r >> 1) | ((((r >> 3) ^ r) & 1) << 3);
    endfunction

    function automatic int exp_out();
        if (m_roll && !m_pause) return m_lfsr;
        if (m_hist.size() == 0) return 0;
        return m_pause ? m_hist[0] : m_hist[m_idx];
    endfunction

    task automatic model_apply(input bit r, input bit st, input bit pv, input bit sl, input int sd);
        int ph;
        int div;
        if (r) begin
            m_lfsr = 1; m_roll = 0; m_pause = 0; m_t = 0; m_idx = 0;
            m_hist.delete();
        end else if (st) begin
            m_roll = 1; m_pause = 0; m_t = 0; m_idx = 0;
        end else if (m_roll && m_pause) begin
            if (pv) m_pause = 0;
        end else if (m_roll) begin
            if (pv) begin
                m_pause = 1;
            end else begin
                ph  = m_t / PHASE_CYCLES;
                div = BASE_DIV << ph;
                if ((((m_t % PHASE_CYCLES) + 1) % div) == 0) m_lfsr = lfsr_step(m_lfsr);
                m_t++;
                if (m_t == NPHASE * PHASE_CYCLES) begin
                    m_roll = 0;
                    m_hist.push_front(m_lfsr);
                    if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_back());
                end
            end
        end else begin
            if (pv) begin
                if (m_idx < m_hist.size() - 1) m_idx++;
            end else if (sl) begin
                m_lfsr = (sd == 0) ? 1 : sd;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit pv, input bit sl, input logic [W-1:0] sd);
        rst = r; start = st; prev = pv; seed_load = sl; seed = sd;
        @(posedge clk);
        model_apply(r, st, pv, sl, int'(sd));
        #1;
        rst = 1'b0; start = 1'b0; prev = 1'b0; seed_load = 1'b0;
        expect_eq("out", 32'(out), 32'(exp_out()));
        expect_eq("busy", 32'(busy), 32'(m_roll));
        expect_eq("hist_idx", 32'(idx), 32'(m_idx));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0);
    endtask

    task automatic run_until_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            idle();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int prev_v;
        int got[$];
        int seq[14];
        seq = '{9, 4, 2, 1, 8, 12, 14, 15, 7, 11, 5, 10, 13, 6};
        rst = 1'b1; start = 1'b0; prev = 1'b0; seed_load = 1'b0; seed = '0;

        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        expect_eq("rst_out", 32'(out), 0);
        expect_eq("rst_busy", 32'(busy), 0);
        expect_eq("rst_idx", 32'(idx), 0);

        // seeded roll: tick sequence, duration, final value
        cyc(0, 0, 0, 1, 4'h3);
        cyc(0, 1, 0, 0, '0);
        prev_v = int'(out);
        n = 0;
        while (busy && n < 200) begin
            idle();
            n++;
            if (int'(out) != prev_v) begin
                got.push_back(int'(out));
                prev_v = int'(out);
            end
        end
        expect_eq("roll_len", n, 48);
        expect_eq("tick_cnt", got.size(), 14);
        for (int i = 0; i < 14; i++) begin
            expect_eq("tick_seq", (i < got.size()) ? got[i] : -1, seq[i]);
        end
        expect_eq("final1", 32'(out), 4'h6);

        // pause in phase 1, hold, resume
        cyc(0, 1, 0, 0, '0);
        repeat (21) idle();
        cyc(0, 0, 1, 0, '0);
        for (int i = 0; i < 10; i++) begin
            idle();
            expect_eq("pause_out", 32'(out), 4'h6);
            expect_eq("pause_busy", 32'(busy), 1);
        end
        cyc(0, 0, 1, 0, '0);
        run_until_idle(n);
        expect_eq("resume_len", n, 27);
        expect_eq("final2", 32'(out), 4'hD);

        // third roll, then browse history
        cyc(0, 1, 0, 0, '0);
        run_until_idle(n);
        expect_eq("final3", 32'(out), 4'hA);
        expect_eq("browse_idx0", 32'(idx), 0);
        cyc(0, 0, 1, 0, '0);
        expect_eq("browse_idx1", 32'(idx), 1);
        expect_eq("browse_out1", 32'(out), 4'hD);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 1, 0, '0);
        expect_eq("browse_sat", 32'(idx), 1);
        expect_eq("browse_out3", 32'(out), 4'hD);
        cyc(0, 1, 0, 0, '0);
        expect_eq("start_idx", 32'(idx), 0);

        // start and prev together mid-roll restarts without pausing
        repeat (9) idle();
        cyc(0, 1, 1, 0, '0);
        expect_eq("restart_busy", 32'(busy), 1);
        run_until_idle(n);
        expect_eq("restart_len", n, 48);

        // zero seed, and seed load ignored during a roll
        cyc(0, 0, 0, 1, 4'h0);
        cyc(0, 1, 0, 0, '0);
        expect_eq("zero_seed", 32'(out), 1);
        idle();
        idle();
        expect_eq("first_tick", 32'(out), 4'h8);
        cyc(0, 0, 0, 1, 4'h5);
        idle();
        expect_eq("seed_ignored", 32'(out), 4'hC);
        run_until_idle(n);

        // reset mid-roll aborts with an empty history
        cyc(0, 1, 0, 0, '0);
        repeat (19) idle();
        cyc(1, 0, 0, 0, '0);
        expect_eq("abort_out", 32'(out), 0);
        expect_eq("abort_busy", 32'(busy), 0);
        cyc(0, 0, 1, 0, '0);
        expect_eq("abort_idx", 32'(idx), 0);
        expect_eq("abort_hist", 32'(out), 0);

        repeat (3000) begin
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                W'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
